trace_event_collector: RTL
==========================

# trace_event_collector

Synthesizable, N-core successor to the per-core simulation trace monitor and r3 checker in the compute-tile bench. It watches the execution trace of every core, shadows each core's r3, and decodes the OpenRISC `l.nop K` simulation hooks (exit, report, putc) into events. Events are buffered per core and merged round-robin into one valid/ready event stream. It also tracks per-core and cross-core termination.

## Interface

Parameters:
- `NUMCORES`, default 1: number of traced cores, from 1 to 16.
- `DEPTH`, default 4: per-core event FIFO depth; must be a power of two and at least 2.
- `TERM_CROSS_NUM`, default `NUMCORES`: number of terminated cores that asserts `termination_all`.

Ports (`W = max(1, clog2(NUMCORES))`):
- `clk` in 1: single clock.
- `rst_sys_n` in 1: reset, asynchronous, active-low.
- `trace_enable` in N: per-core retire strobe.
- `trace_insn` in 32N: retired instruction; core i occupies `[32i+31:32i]`.
- `trace_pc` in 32N: retired PC.
- `trace_wben` in N: writeback enable.
- `trace_wbreg` in 5N: writeback register index.
- `trace_wbdata` in 32N: writeback data.
- `event_valid` out 1: output event available.
- `event_ready` in 1: consumer accepts the event.
- `event_core` out W: source core index.
- `event_type` out 2: 1 = EXIT, 2 = REPORT, 3 = PUTC.
- `event_data` out 32: r3 of the source core at the nop.
- `event_pc` out 32: PC of the nop.
- `overflow` out N: sticky; set when an event was dropped for that core.
- `termination` out N: sticky; that core has executed EXIT.
- `termination_all` out 1: popcount(`termination`) ≥ `TERM_CROSS_NUM`.

## Operation

- **r3 shadow, per core.** On `enable && wben && wbreg==3`, update `r3 <= wbdata`. The reset value is 0.
- **Decode, per core.** An instruction is an event when `enable` is high and `insn[31:16]==16'h1500`. K is `insn[15:0]`:
  - K = 0x0001 → EXIT.
  - K = 0x0002 → REPORT.
  - K = 0x0004 → PUTC.
  - Every other K, including 0, is ignored.
- **Event payload.** `event_data` is the shadow value *before* any same-cycle update. Such an update cannot come from the nop itself.
- **Buffering.** Each event is pushed into its core's FIFO. The entry is {type, r3, pc}.
- **Full FIFO.** If the FIFO is full, the event is dropped and `overflow[i]` is set until reset.
- **Termination vs. buffering.** EXIT sets `termination[i]` even when the event itself is dropped.
- **Arbiter.**
  - Round-robin over non-empty FIFOs, starting from the `rr_ptr` priority pointer.
  - On each grant, `rr_ptr` moves to grant+1, wrapping from N−1 to 0.
  - The grant pops the head into the output register.
- **Output register.** It loads when empty, or when `event_valid && event_ready` in the same cycle (back-to-back, one event per cycle).
- **Output stability.** While `event_valid && !event_ready`, all event outputs hold stable.
- **Multi-core events.** Simultaneous events on several cores are all captured in the same cycle, with no loss while the FIFOs have room.

## Timing

- **Reset values.** All outputs are 0 in reset, and every FIFO is empty. `termination_all` is 0 unless `TERM_CROSS_NUM==0`, in which case it is 1.
- **Reset mid-operation.** Assertion clears all state asynchronously, including pending events and sticky flags.
- **Termination latency.** An EXIT retired in cycle t gives `termination[i]` high from cycle t+1. `termination_all` is combinational from the registered flags.
- **Event latency.** An event retired in cycle t is written to its FIFO at the end of t. With an idle output and a matching `rr_ptr`, `event_valid` is high from cycle t+2.
- **Full FIFO with simultaneous pop.** Push and pop in the same cycle on a full FIFO succeeds: the pop is counted first and nothing is dropped.
- **Sustained throughput.** One event per cycle across all cores. A core producing an event every cycle while others are also active will overflow.

## Structure

- **Package `trace_event_pkg`.**
  - `event_type_t` enum.
  - NOP code constants: `NOP_EXIT`, `NOP_REPORT`, `NOP_PUTC`, and `NOP_PREFIX = 16'h1500`.
  - `trace_event_t` packed struct {type, data, pc}.
- **Sub-module `trace_event_fifo`.**
  - Synchronous FIFO, depth `DEPTH`, with pointers of `clog2(DEPTH)+1` bits.
  - Outputs: `full`, `empty`, and head data.
  - Instantiated once per core in a generate loop.
- **Top level.** The r3 shadows, decode, arbiter, output register and termination logic.

## Test plan

- **Single putc.** NUMCORES=1. Write r3=0x41, then retire `0x15000004` at PC 0x100 → one event {core 0, PUTC, 0x41, 0x100}, with `event_valid` two cycles after the nop.
- **Back-pressure.** Hold `event_ready` low for 10 cycles with 3 events queued → outputs stay stable. Release → three events drain on consecutive cycles, in order.
- **Round-robin.** NUMCORES=4. All cores retire REPORT in the same cycle with r3 = core index → events emitted for cores 0,1,2,3. A repeat burst starts at the next pointer position.
- **Overflow.** DEPTH=4 with `event_ready` held low. Core 0 issues 6 PUTCs → 5 are retained (4 in the FIFO, 1 in the output register), 1 is dropped, and `overflow[0]`=1.
- **Termination.** NUMCORES=4, TERM_CROSS_NUM=2.
  - Core 1 EXITs → `termination`=0010, `termination_all`=0.
  - Core 3 EXITs → `termination`=1010, `termination_all`=1.
  - EXIT on a full FIFO still sets the flag.
- **Async reset mid-stream.** Pull `rst_sys_n` low between clock edges with events queued → all outputs are 0 immediately. After release, the next event has 2-cycle latency.

Source files
------------

// File: rtl/trace_event_pkg.sv
// Shared types and l.nop hook codes for the trace event collector.
package trace_event_pkg;

  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_EXIT   = 2'd1,
    EV_REPORT = 2'd2,
    EV_PUTC   = 2'd3
  } event_type_t;

  localparam logic [15:0] NOP_PREFIX = 16'h1500;
  localparam logic [15:0] NOP_EXIT   = 16'h0001;
  localparam logic [15:0] NOP_REPORT = 16'h0002;
  localparam logic [15:0] NOP_PUTC   = 16'h0004;

  typedef struct packed {
    event_type_t etype;
    logic [31:0] data;
    logic [31:0] pc;
  } trace_event_t;

endpackage

// File: rtl/trace_event_fifo.sv
// Per-core synchronous event FIFO; extra pointer bit distinguishes full from empty.
module trace_event_fifo
  import trace_event_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  trace_event_t push_data,
  input  logic         pop,
  output trace_event_t head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  trace_event_t mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // On a full FIFO with a same-cycle pop the write lands in the slot being read out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/trace_event_collector.sv
// Decodes l.nop simulation hooks from N core traces, buffers them per core and
// merges them round-robin into a single valid/ready event stream.
module trace_event_collector
  import trace_event_pkg::*;
#(
  parameter  int unsigned NUMCORES       = 1,
  parameter  int unsigned DEPTH          = 4,
  parameter  int unsigned TERM_CROSS_NUM = NUMCORES,
  localparam int unsigned W              = (NUMCORES > 1) ? $clog2(NUMCORES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_sys_n,
  input  logic [NUMCORES-1:0]     trace_enable,
  input  logic [32*NUMCORES-1:0]  trace_insn,
  input  logic [32*NUMCORES-1:0]  trace_pc,
  input  logic [NUMCORES-1:0]     trace_wben,
  input  logic [5*NUMCORES-1:0]   trace_wbreg,
  input  logic [32*NUMCORES-1:0]  trace_wbdata,
  output logic                    event_valid,
  input  logic                    event_ready,
  output logic [W-1:0]            event_core,
  output logic [1:0]              event_type,
  output logic [31:0]             event_data,
  output logic [31:0]             event_pc,
  output logic [NUMCORES-1:0]     overflow,
  output logic [NUMCORES-1:0]     termination,
  output logic                    termination_all
);

  logic [NUMCORES-1:0] ev_hit, ev_exit, fifo_full, fifo_empty, push, pop;
  trace_event_t        ev_entry  [NUMCORES];
  trace_event_t        fifo_head [NUMCORES];

  for (genvar g = 0; g < NUMCORES; g++) begin : g_core
    logic [31:0] insn;
    logic [31:0] r3;
    event_type_t etype;

    assign insn = trace_insn[32*g +: 32];

    always_comb begin
      etype = EV_NONE;
      if (trace_enable[g] && insn[31:16] == NOP_PREFIX) begin
        case (insn[15:0])
          NOP_EXIT:   etype = EV_EXIT;
          NOP_REPORT: etype = EV_REPORT;
          NOP_PUTC:   etype = EV_PUTC;
          default:    etype = EV_NONE;
        endcase
      end
    end

    assign ev_hit[g]   = (etype != EV_NONE);
    assign ev_exit[g]  = (etype == EV_EXIT);
    assign ev_entry[g] = {etype, r3, trace_pc[32*g +: 32]};
    assign push[g]     = ev_hit[g] && (!fifo_full[g] || pop[g]);

    always_ff @(posedge clk or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
        r3 <= '0;
      end else if (trace_enable[g] && trace_wben[g] && trace_wbreg[5*g +: 5] == 5'd3) begin
        r3 <= trace_wbdata[32*g +: 32];
      end
    end

    trace_event_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_sys_n),
      .push      (push[g]),
      .push_data (ev_entry[g]),
      .pop       (pop[g]),
      .head      (fifo_head[g]),
      .full      (fifo_full[g]),
      .empty     (fifo_empty[g])
    );
  end

  logic [W-1:0] rr_ptr, hi_idx, lo_idx, gnt_idx;
  logic         hi_found, lo_found, gnt_valid, load;
  trace_event_t hi_head, lo_head, gnt_head;
  logic [4:0]   term_cnt;

  // Two passes: first non-empty at or above rr_ptr, else first non-empty overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    hi_head  = '0;
    lo_head  = '0;
    for (int unsigned j = 0; j < NUMCORES; j++) begin
      if (!fifo_empty[j]) begin
        if (!hi_found && j >= 32'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = W'(j);
          hi_head  = fifo_head[j];
        end
        if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = W'(j);
          lo_head  = fifo_head[j];
        end
      end
    end
    gnt_valid = hi_found || lo_found;
    gnt_idx   = hi_found ? hi_idx : lo_idx;
    gnt_head  = hi_found ? hi_head : lo_head;
  end

  assign load = !event_valid || event_ready;

  always_comb begin
    pop = '0;
    for (int unsigned j = 0; j < NUMCORES; j++) begin
      pop[j] = load && gnt_valid && (32'(gnt_idx) == j);
    end
  end

  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      event_valid <= 1'b0;
      event_core  <= '0;
      event_type  <= '0;
      event_data  <= '0;
      event_pc    <= '0;
      rr_ptr      <= '0;
      overflow    <= '0;
      termination <= '0;
    end else begin
      if (load) begin
        event_valid <= gnt_valid;
        if (gnt_valid) begin
          event_core <= gnt_idx;
          event_type <= gnt_head.etype;
          event_data <= gnt_head.data;
          event_pc   <= gnt_head.pc;
          rr_ptr     <= (32'(gnt_idx) == NUMCORES - 1) ? '0 : gnt_idx + W'(1);
        end
      end
      overflow    <= overflow | (ev_hit & fifo_full & ~pop);
      termination <= termination | ev_exit;
    end
  end

  always_comb begin
    term_cnt = '0;
    for (int unsigned j = 0; j < NUMCORES; j++) begin
      term_cnt = term_cnt + 5'(termination[j]);
    end
  end

  assign termination_all = (32'(term_cnt) >= TERM_CROSS_NUM);

endmodule
